// File: rtl/pe_pkg.sv
// Shared constants, FSM state type and a real-to-fixed helper for the
// convolution sequencer and its benches.
package pe_pkg;
  localparam int WIDTH  = 32;
  localparam int FBITS  = 24;
  localparam int N_REG  = 31;
  localparam int PAD    = (N_REG - 1) / 2;
  localparam int STRIDE = 2;
  localparam int LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CALC  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Truncating conversion of a real value to signed Q(WIDTH-FBITS).FBITS.
  function automatic logic [WIDTH-1:0] to_q(input real v);
    return WIDTH'($rtoi(v * (2.0 ** FBITS)));
  endfunction
endpackage

// File: rtl/pe_conv_seq_if.sv
// Sample-in / result-out stream pair of the convolution sequencer.
interface pe_conv_seq_if #(
  parameter int WIDTH = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/pe_window_shift.sv
// Sliding input window: entry 0 is the oldest sample, entry N_REG-1 the newest.
module pe_window_shift #(
  parameter int WIDTH = 32,
  parameter int N_REG = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_shift_en,
  input  logic                   i_zero_ins,
  input  logic [WIDTH-1:0]       i_data,
  output logic [N_REG*WIDTH-1:0] o_win
);
  logic [WIDTH-1:0] r_win [N_REG];

  // Clear on job start, otherwise shift towards index 0 with optional zero fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) r_win[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < N_REG; i++) r_win[i] <= '0;
    end else if (i_shift_en) begin
      for (int i = 0; i < N_REG - 1; i++) r_win[i] <= r_win[i+1];
      r_win[N_REG-1] <= i_zero_ins ? {WIDTH{1'b0}} : i_data;
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_pack
    assign o_win[g*WIDTH +: WIDTH] = r_win[g];
  end
endmodule

// File: rtl/pe_conv_seq.sv
// Streams a 1-D signal through one external combinational PE as a strided,
// zero-padded convolution; holds weights, window and bias/alpha config.
module pe_conv_seq #(
  parameter int WIDTH  = pe_pkg::WIDTH,
  parameter int N_REG  = pe_pkg::N_REG,
  parameter int STRIDE = pe_pkg::STRIDE,
  parameter int LEN_W  = pe_pkg::LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic [WIDTH-1:0]       cfg_bias,
  input  logic [WIDTH-1:0]       cfg_alpha,
  input  logic                   w_we,
  input  logic [4:0]             w_idx,
  input  logic [WIDTH-1:0]       w_data,
  pe_conv_seq_if.slave           strm,
  output logic                   busy,
  output logic                   done,
  output logic [N_REG*WIDTH-1:0] pe_all_a,
  output logic [N_REG*WIDTH-1:0] pe_all_w,
  output logic [WIDTH-1:0]       pe_b,
  output logic [WIDTH-1:0]       pe_alpha,
  input  logic [WIDTH-1:0]       pe_y
);
  import pe_pkg::*;

  // First window needs the centre tap plus the right-hand half filled.
  localparam int FIRST_FILL = N_REG - (N_REG - 1) / 2;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_len, r_in_cnt, r_out_cnt, r_n_out, r_shift_left;
  logic [WIDTH-1:0] r_bias, r_alpha, r_m_data;
  logic [WIDTH-1:0] r_w [N_REG];
  logic [LEN_W:0]   w_n_out_full;
  logic             w_clear, w_shift, w_zero, w_s_ready;
  logic             w_capture, w_out_hs, w_start_acc;

  assign w_n_out_full = ({1'b0, cfg_len} + (LEN_W+1)'(STRIDE - 1)) / (LEN_W+1)'(STRIDE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_shift     = 1'b0;
    w_zero      = 1'b0;
    w_s_ready   = 1'b0;
    w_capture   = 1'b0;
    w_out_hs    = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_clear     = 1'b1;
          w_next      = (cfg_len == {LEN_W{1'b0}}) ? FIN : SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (r_in_cnt < r_len) begin
          w_s_ready = 1'b1;
          w_shift   = strm.s_valid;
        end else begin
          w_shift = 1'b1;
          w_zero  = 1'b1;
        end
        if (w_shift && (r_shift_left == LEN_W'(1))) w_next = CALC;
        else                                        w_next = SHIFT;
      end
      CALC: begin
        w_capture = 1'b1;
        w_next    = OUT;
      end
      OUT: begin
        if (strm.m_ready) begin
          w_out_hs = 1'b1;
          w_next   = ((r_out_cnt + LEN_W'(1)) == r_n_out) ? FIN : SHIFT;
        end else begin
          w_next = OUT;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Job configuration, counters and the captured PE result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_bias       <= '0;
      r_alpha      <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_n_out      <= '0;
      r_shift_left <= '0;
      r_m_data     <= '0;
    end else begin
      if (w_start_acc) begin
        r_len        <= cfg_len;
        r_bias       <= cfg_bias;
        r_alpha      <= cfg_alpha;
        r_in_cnt     <= '0;
        r_out_cnt    <= '0;
        r_n_out      <= w_n_out_full[LEN_W-1:0];
        r_shift_left <= LEN_W'(FIRST_FILL);
      end else begin
        if (w_shift)            r_shift_left <= r_shift_left - LEN_W'(1);
        if (w_shift && !w_zero) r_in_cnt     <= r_in_cnt + LEN_W'(1);
        if (w_out_hs) begin
          r_out_cnt    <= r_out_cnt + LEN_W'(1);
          r_shift_left <= LEN_W'(STRIDE);
        end
      end
      if (w_capture) r_m_data <= pe_y;
    end
  end

  // Weight bank; writable only while idle, out-of-range taps dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) r_w[i] <= '0;
    end else if (w_we && (r_state == IDLE) && (w_idx < 5'(N_REG))) begin
      r_w[w_idx] <= w_data;
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_wpack
    assign pe_all_w[g*WIDTH +: WIDTH] = r_w[g];
  end

  pe_window_shift #(
    .WIDTH (WIDTH),
    .N_REG (N_REG)
  ) u_win (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_shift_en (w_shift),
    .i_zero_ins (w_zero),
    .i_data     (strm.s_data),
    .o_win      (pe_all_a)
  );

  assign strm.s_ready = w_s_ready;
  assign strm.m_valid = (r_state == OUT);
  assign strm.m_data  = r_m_data;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == FIN);
  assign pe_b         = r_bias;
  assign pe_alpha     = r_alpha;
endmodule

// File: tb/tb_pe_conv_seq.sv
// Self-checking bench: a behavioural PE closes the loop, expected results come
// from direct index arithmetic on the sample list (centre k*STRIDE, zero padding).
module tb_pe_conv_seq;
  import pe_pkg::*;

  localparam int W  = 32;
  localparam int NR = 31;
  localparam int NB = NR * W;
  localparam int ST = 2;
  localparam int PD = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cfg_len = '0;
  logic [W-1:0]  cfg_bias = '0, cfg_alpha = '0;
  logic          w_we = 1'b0;
  logic [4:0]    w_idx = '0;
  logic [W-1:0]  w_data = '0;
  logic          busy, done;
  logic [NB-1:0] pe_all_a, pe_all_w;
  logic [W-1:0]  pe_b, pe_alpha, pe_y;

  logic signed [31:0] smp [64];
  logic signed [31:0] wt  [NR];
  logic [31:0]        cur_b, cur_al;
  int                 L_cur;
  logic [31:0]        obs [$];
  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [31:0]        exp_imp [4] = '{32'h00000000, 32'h00800000, 32'h01000000, 32'h01800000};

  always #5 clk = ~clk;

  pe_conv_seq_if #(.WIDTH(W)) strm ();

  pe_conv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_bias  (cfg_bias),
    .cfg_alpha (cfg_alpha),
    .w_we      (w_we),
    .w_idx     (w_idx),
    .w_data    (w_data),
    .strm      (strm),
    .busy      (busy),
    .done      (done),
    .pe_all_a  (pe_all_a),
    .pe_all_w  (pe_all_w),
    .pe_b      (pe_b),
    .pe_alpha  (pe_alpha),
    .pe_y      (pe_y)
  );

  function automatic logic [31:0] prelu(input longint acc, input logic [31:0] b, input logic [31:0] al);
    longint y;
    y = (acc >>> FBITS) + longint'($signed(b));
    if (y < 0) y = (y * longint'($signed(al))) >>> FBITS;
    return y[31:0];
  endfunction

  always_comb begin : pe_model
    longint acc;
    acc = 0;
    for (int i = 0; i < NR; i++)
      acc += longint'($signed(pe_all_a[i*W +: W])) * longint'($signed(pe_all_w[i*W +: W]));
    pe_y = prelu(acc, pe_b, pe_alpha);
  end

  function automatic logic [31:0] ref_out(input int k);
    longint acc;
    int j;
    acc = 0;
    for (int i = 0; i < NR; i++) begin
      j = k * ST - PD + i;
      if (j >= 0 && j < L_cur) acc += longint'(smp[j]) * longint'(wt[i]);
    end
    return prelu(acc, cur_b, cur_al);
  endfunction

  task automatic load_weights();
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      w_we = 1'b1; w_idx = 5'(i); w_data = wt[i];
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic start_job(input int L, input logic [31:0] b, input logic [31:0] al);
    L_cur = L; cur_b = b; cur_al = al;
    @(negedge clk);
    start = 1'b1; cfg_len = 16'(L); cfg_bias = b; cfg_alpha = al;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_job(input int sv_mode, input int mr_mode, output bit seen_done,
                         output int consumed, output int proto_errs, output int cycles,
                         output bit tail_ok);
    int hold;
    bit prev_stall, sv;
    logic [31:0] prev_data;
    hold = 0; prev_stall = 1'b0; prev_data = '0;
    seen_done = 1'b0; consumed = 0; proto_errs = 0; cycles = 0;
    obs.delete();
    while (!seen_done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (prev_stall && (strm.m_valid !== 1'b1 || strm.m_data !== prev_data)) proto_errs++;
      if (strm.m_valid === 1'b1 && strm.s_ready !== 1'b0) proto_errs++;
      if (consumed >= L_cur && strm.s_ready !== 1'b0) proto_errs++;
      if (done === 1'b1) seen_done = 1'b1;
      case (sv_mode)
        0:       sv = 1'b1;
        1:       sv = cycles[0];
        default: sv = 1'($urandom_range(0, 1));
      endcase
      strm.s_valid = (consumed < L_cur) ? sv : 1'b0;
      strm.s_data  = (consumed < L_cur) ? smp[consumed] : 32'($urandom);
      case (mr_mode)
        0: strm.m_ready = 1'b1;
        1: begin
          if (strm.m_valid && hold < 5) begin strm.m_ready = 1'b0; hold++; end
          else strm.m_ready = 1'b1;
        end
        default: strm.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (strm.s_valid && strm.s_ready) consumed++;
      if (strm.m_valid && strm.m_ready) begin obs.push_back(strm.m_data); hold = 0; end
      prev_stall = strm.m_valid && !strm.m_ready;
      prev_data  = strm.m_data;
    end
    strm.s_valid = 1'b0; strm.m_ready = 1'b0;
    @(negedge clk);
    tail_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic set_impulse_and_ramp();
    for (int i = 0; i < NR; i++) wt[i] = '0;
    wt[15] = to_q(1.0);
    for (int n = 0; n < 64; n++) smp[n] = to_q(n * 0.25);
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if ({strm.m_valid, strm.s_ready, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {strm.m_valid, strm.s_ready, busy, done}); end
    n_tests++; if (strm.m_data !== 32'h0) begin n_fail++; $display("FAIL reset_mdata: got %h expected 0", strm.m_data); end
    n_tests++; if (pe_all_a !== '0 || pe_all_w !== '0) begin n_fail++; $display("FAIL reset_win_w: window or weights nonzero"); end
    n_tests++; if (pe_b !== 32'h0 || pe_alpha !== 32'h0) begin n_fail++; $display("FAIL reset_cfg: got b=%h alpha=%h expected 0", pe_b, pe_alpha); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || strm.m_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy=%b m_valid=%b expected 0", busy, strm.m_valid); end
  endtask

  task automatic test_impulse();
    bit sd, tl; int cons, pe, cyc;
    set_impulse_and_ramp();
    load_weights();
    start_job(8, 32'h0, to_q(0.5));
    run_job(0, 0, sd, cons, pe, cyc, tl);
    n_tests++; if (!sd) begin n_fail++; $display("FAIL impulse_done: no done within budget"); end
    n_tests++; if (cons != 8) begin n_fail++; $display("FAIL impulse_consumed: got %0d expected 8", cons); end
    n_tests++; if (obs.size() != 4) begin n_fail++; $display("FAIL impulse_count: got %0d expected 4", obs.size()); end
    for (int k = 0; k < 4 && k < obs.size(); k++) begin
      n_tests++; if (obs[k] !== exp_imp[k]) begin n_fail++; $display("FAIL impulse_out%0d: got %h expected %h", k, obs[k], exp_imp[k]); end
    end
    n_tests++; if (pe != 0 || !tl) begin n_fail++; $display("FAIL impulse_proto: errs=%0d tail_ok=%0d expected 0/1", pe, tl); end
  endtask

  task automatic test_prelu();
    bit sd, tl; int cons, pe, cyc;
    smp[0] = to_q(-2.0);
    start_job(1, 32'h0, to_q(0.25));
    run_job(0, 0, sd, cons, pe, cyc, tl);
    n_tests++; if (obs.size() != 1) begin n_fail++; $display("FAIL prelu_count: got %0d expected 1", obs.size()); end
    else begin n_tests++; if (obs[0] !== 32'hFF800000) begin n_fail++; $display("FAIL prelu_out: got %h expected ff800000", obs[0]); end end
    n_tests++; if (!sd || !tl) begin n_fail++; $display("FAIL prelu_done_busy: done=%0d tail_ok=%0d expected 1/1", sd, tl); end
  endtask

  task automatic test_full_taps();
    bit sd, tl; int cons, pe, cyc;
    for (int i = 0; i < NR; i++) wt[i] = to_q(0.5);
    load_weights();
    for (int n = 0; n < 4; n++) smp[n] = to_q(1.0);
    start_job(4, to_q(0.9), to_q(0.25));
    run_job(0, 0, sd, cons, pe, cyc, tl);
    n_tests++; if (obs.size() != 2) begin n_fail++; $display("FAIL full_count: got %0d expected 2", obs.size()); end
    for (int k = 0; k < obs.size() && k < 2; k++) begin
      n_tests++; if (obs[k] !== 32'h02E66666) begin n_fail++; $display("FAIL full_out%0d: got %h expected 02e66666", k, obs[k]); end
    end
    n_tests++; if (pe != 0 || cons != 4) begin n_fail++; $display("FAIL full_sready: errs=%0d consumed=%0d expected 0/4", pe, cons); end
  endtask

  task automatic test_backpressure();
    bit sd, tl; int cons, pe, cyc;
    set_impulse_and_ramp();
    load_weights();
    start_job(8, 32'h0, to_q(0.5));
    run_job(1, 1, sd, cons, pe, cyc, tl);
    n_tests++; if (obs.size() != 4 || cons != 8) begin n_fail++; $display("FAIL bp_count: got %0d outs %0d samples expected 4/8", obs.size(), cons); end
    for (int k = 0; k < 4 && k < obs.size(); k++) begin
      n_tests++; if (obs[k] !== exp_imp[k]) begin n_fail++; $display("FAIL bp_out%0d: got %h expected %h", k, obs[k], exp_imp[k]); end
    end
    n_tests++; if (pe != 0 || !sd || !tl) begin n_fail++; $display("FAIL bp_proto: errs=%0d done=%0d tail=%0d expected 0/1/1", pe, sd, tl); end
  endtask

  task automatic test_config_guards();
    bit sd, tl; int cons, pe, cyc;
    logic [NB-1:0] expw;
    logic [31:0] exp_g [2] = '{32'h00200000, 32'h00A00000};
    set_impulse_and_ramp();
    for (int i = 0; i < NR; i++) expw[i*W +: W] = wt[i];
    start_job(4, to_q(0.125), to_q(0.5));
    repeat (3) begin
      @(negedge clk);
      strm.s_valid = 1'b0; w_we = 1'b1; w_idx = 5'd15; w_data = 32'h7FFF0000;
      start = 1'b1; cfg_len = 16'd9; cfg_bias = to_q(-1.0);
    end
    @(negedge clk);
    w_we = 1'b0; start = 1'b0;
    n_tests++; if (pe_all_w !== expw) begin n_fail++; $display("FAIL guard_wwe: tap15 got %h expected %h", pe_all_w[15*W +: W], expw[15*W +: W]); end
    n_tests++; if (pe_b !== to_q(0.125) || busy !== 1'b1) begin n_fail++; $display("FAIL guard_start: b=%h busy=%b expected %h/1", pe_b, busy, to_q(0.125)); end
    run_job(0, 0, sd, cons, pe, cyc, tl);
    n_tests++; if (obs.size() != 2 || cons != 4) begin n_fail++; $display("FAIL guard_count: got %0d outs %0d samples expected 2/4", obs.size(), cons); end
    for (int k = 0; k < 2 && k < obs.size(); k++) begin
      n_tests++; if (obs[k] !== exp_g[k]) begin n_fail++; $display("FAIL guard_out%0d: got %h expected %h", k, obs[k], exp_g[k]); end
    end
    start_job(0, 32'h0, 32'h0);
    run_job(0, 0, sd, cons, pe, cyc, tl);
    n_tests++; if (!sd || cyc != 1 || obs.size() != 0 || !tl) begin n_fail++; $display("FAIL len0: done=%0d cycles=%0d outs=%0d tail=%0d expected 1/1/0/1", sd, cyc, obs.size(), tl); end
  endtask

  task automatic test_reset_mid_out();
    bit sd, tl, reached; int cons, pe, cyc, idx;
    set_impulse_and_ramp();
    load_weights();
    start_job(8, 32'h0, to_q(0.5));
    idx = 0; reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      if (strm.m_valid === 1'b1) reached = 1'b1;
      strm.s_valid = (idx < 8); strm.s_data = smp[idx]; strm.m_ready = 1'b0;
      if (strm.s_valid && strm.s_ready) idx++;
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL rst_reach_out: m_valid never rose"); end
    @(negedge clk);
    rst_n = 1'b0; strm.s_valid = 1'b0;
    #1;
    n_tests++; if (strm.m_valid !== 1'b0 || busy !== 1'b0 || pe_all_w !== '0) begin n_fail++; $display("FAIL rst_mid_out: m_valid=%b busy=%b w_zero=%0d expected 0/0/1", strm.m_valid, busy, pe_all_w == '0); end
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b expected 0", done); end
    end
    rst_n = 1'b1;
    load_weights();
    start_job(8, 32'h0, to_q(0.5));
    run_job(0, 0, sd, cons, pe, cyc, tl);
    n_tests++; if (obs.size() != 4) begin n_fail++; $display("FAIL rst_rerun_count: got %0d expected 4", obs.size()); end
    for (int k = 0; k < 4 && k < obs.size(); k++) begin
      n_tests++; if (obs[k] !== exp_imp[k]) begin n_fail++; $display("FAIL rst_rerun_out%0d: got %h expected %h", k, obs[k], exp_imp[k]); end
    end
  endtask

  task automatic test_random();
    bit sd, tl; int cons, pe, cyc, L;
    logic [31:0] e;
    for (int job = 0; job < 3; job++) begin
      for (int i = 0; i < NR; i++) wt[i] = int'($urandom_range(0, 33554432)) - 16777216;
      for (int n = 0; n < 64; n++) smp[n] = int'($urandom_range(0, 134217728)) - 67108864;
      L = int'($urandom_range(1, 40));
      load_weights();
      start_job(L, 32'(int'($urandom_range(0, 33554432)) - 16777216), 32'($urandom_range(0, 16777216)));
      run_job(2, 2, sd, cons, pe, cyc, tl);
      n_tests++; if (obs.size() != (L + 1) / 2 || cons != L) begin n_fail++; $display("FAIL rand%0d_count: got %0d outs %0d samples expected %0d/%0d", job, obs.size(), cons, (L + 1) / 2, L); end
      for (int k = 0; k < obs.size() && k < (L + 1) / 2; k++) begin
        e = ref_out(k);
        n_tests++; if (obs[k] !== e) begin n_fail++; $display("FAIL rand%0d_out%0d: got %h expected %h", job, k, obs[k], e); end
      end
      n_tests++; if (pe != 0 || !sd || !tl) begin n_fail++; $display("FAIL rand%0d_proto: errs=%0d done=%0d tail=%0d expected 0/1/1", job, pe, sd, tl); end
    end
  endtask

  initial begin
    strm.s_valid = 1'b0;
    strm.s_data  = '0;
    strm.m_ready = 1'b0;
    test_reset();
    test_impulse();
    test_prelu();
    test_full_taps();
    test_backpressure();
    test_config_guards();
    test_reset_mid_out();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_conv_seq.md
Name: pe_conv_seq

Overview:
- Sequencer that streams a 1-D input signal through one combinational PE (31-tap MAC + bias + PReLU, Q8.24) as a strided, zero-padded convolution, one output channel.
- Holds the weight registers, the sliding input window, and bias/alpha config; drives the PE's all_a/all_w/b/alpha buses and captures y.
- Sits between the sample stream (valid/ready) and the output stream; a conv-layer wrapper instantiates this block plus the PE.

Parameters:
- WIDTH, 32, sample/weight/result width, signed Q(WIDTH-FBITS).FBITS
- FBITS, 24, fractional bits
- N_REG, 31, kernel taps (odd)
- STRIDE, 2, window advance per output (>=1)
- LEN_W, 16, width of the length field

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- cfg_len  in  LEN_W  input sample count L, latched on start
- cfg_bias  in  WIDTH  bias, latched on start
- cfg_alpha  in  WIDTH  PReLU slope, latched on start
- w_we  in  1  weight write strobe; honoured only in IDLE
- w_idx  in  5  tap index 0..N_REG-1; idx>=N_REG ignored
- w_data  in  WIDTH  weight value
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&s_ready
- s_data  in  WIDTH  input sample
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_data  out  WIDTH  registered PE result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output handshake
- pe_all_a  out  N_REG*WIDTH  window, tap i at [i*WIDTH +: WIDTH]
- pe_all_w  out  N_REG*WIDTH  weights, same packing
- pe_b  out  WIDTH  latched bias
- pe_alpha  out  WIDTH  latched alpha
- pe_y  in  WIDTH  PE result, combinational from the above

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Window, weights, bias, alpha, counters and m_data cleared to 0.
  - m_valid=0, s_ready=0, busy=0, done=0.
  - Reset mid-operation aborts the job: no done pulse, and weights must be reloaded.
- Window convention:
  - win[0] is the oldest sample, win[N_REG-1] the newest.
  - A shift moves win[i] <= win[i+1] and loads win[N_REG-1] with the new value.
  - PAD = (N_REG-1)/2 = 15.
- IDLE:
  - w_we writes weight[w_idx].
  - On start: latch cfg, clear the window, set in_cnt=0, out_cnt=0, shift_left=N_REG-PAD (16).
  - If cfg_len==0: go to FIN. Otherwise go to SHIFT.
  - start while not IDLE is ignored; w_we while not IDLE is ignored.
- SHIFT (one shift per cycle at most):
  - If in_cnt<L: s_ready=1, and shift in s_data only on handshake (the cycle stalls while s_valid=0); in_cnt++.
  - If in_cnt>=L: s_ready=0 and a zero is shifted in every cycle (tail padding).
  - shift_left is decremented on each shift. When it reaches 0, go to CALC.
- CALC:
  - One settle cycle; m_data <= pe_y at the end of the cycle.
  - Go to OUT.
- OUT:
  - m_valid=1 and m_data is held stable until m_ready.
  - On the handshake, out_cnt++.
  - If out_cnt+1 == ceil(L/STRIDE): go to FIN. Otherwise set shift_left=STRIDE and go to SHIFT.
  - s_ready=0 throughout OUT.
- FIN: done=1 for one cycle, then IDLE.
- Output k is centred on sample k*STRIDE, and ceil(L/STRIDE) outputs are produced in total.
- Latency: m_valid rises 2 cycles after the final shift of each window.
- No arithmetic in this block. Values pass through at full WIDTH; saturation and rounding belong to the PE.

Decomposition:
- Shared package pe_pkg: WIDTH, FBITS, N_REG, PAD, a to_q(real) helper for benches, and the state enum {IDLE, SHIFT, CALC, OUT, FIN}.
- One sub-module, pe_window_shift: N_REG x WIDTH shift register with clear, shift_en, zero-insert select, and packed output.
- The FSM and counters stay in pe_conv_seq.

Test Plan:
- Impulse: weight[15]=1.0 (0x01000000), others 0; bias=0; alpha=0.5; L=8; x[n]=n*0.25 -> 4 outputs, 0x00000000, 0x00800000, 0x01000000, 0x01800000, then a done pulse.
- PReLU: weight[15]=1.0; alpha=0.25; L=1; x[0]=-2.0 -> one output 0xFF800000 (-0.5); busy falls the cycle after done.
- Full taps: all weights 0.5; bias 0.9; L=4; samples 1.0 -> 2 outputs, each 2.9 (0x02E66666±1 LSB from the PE); s_ready never asserted after the 4th sample.
- Backpressure/throttle: hold m_ready=0 for 5 cycles and toggle s_valid every other cycle -> m_data stable, m_valid held, s_ready=0 in OUT, no sample lost or duplicated (ramp check as in the impulse case).
- Config guards: w_we while busy does not change pe_all_w; start while busy is ignored; start with L=0 -> done the next cycle with no m_valid.
- Reset mid-OUT: drop rst_n -> m_valid, busy and pe_all_w are immediately 0; no done; a new job after reload produces correct results.
